sensor_alarm_array: RTL and testbench

Parametrised multi-channel sensor-to-buzzer alarm controller, the next generation of the top-level 8-sensor/8-buzzer state machine. Each channel registers its sensor input, debounces it, drives a gated beep tone while the sensor is active, and holds the alarm for a programmable time after release. An optional latch mode keeps alarms asserted until acknowledged. It sits directly behind the tile's `ui_in` pins and drives `uo_out`.

---
 rtl/sensor_alarm_array.sv | 158 +++++++++++++++
 tb/tb_sensor_alarm_array.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_alarm_array.sv
// sensor_alarm_array
// Multi-channel sensor-to-buzzer alarm controller. Each channel registers
// its sensor, debounces it, raises a steady alarm, gates a shared beep tone
// onto its buzzer while alarmed, and holds the alarm for HOLD clocks after
// release (optionally latching until acknowledged).
//
// Ports
//   clk             single clock
//   rst_n           asynchronous active-low reset
//   ena             global enable; 0 freezes all state, buzzers forced low
//   sensor_i        raw sensor levels, active high
//   ack_i           per-channel acknowledge (only honoured when latched)
//   buzzer_o        gated beep drive per channel
//   alarm_o         steady alarm status per channel
//   active_count_o  number of set alarm_o bits
//
// Channel FSM
//   state    | meaning
//   ---------+-----------------------------------------------------
//   IDLE     | no alarm, waiting for a high sample
//   ARM      | sensor high, counting debounce samples
//   ALARM    | alarm raised, sensor still high
//   HOLDING  | sensor released, alarm held for HOLD clocks
//   LATCHED  | hold expired with LATCH=1, waiting for ack_i
module sensor_alarm_array #(
  parameter int N_CH      = 8,
  parameter int DEBOUNCE  = 4,
  parameter int BEEP_HALF = 5,
  parameter int HOLD      = 8,
  parameter int LATCH     = 0,
  localparam int CNT_W    = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_CH-1:0]  sensor_i,
  input  logic [N_CH-1:0]  ack_i,
  output logic [N_CH-1:0]  buzzer_o,
  output logic [N_CH-1:0]  alarm_o,
  output logic [CNT_W-1:0] active_count_o
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int TW = $clog2(BEEP_HALF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ALARM,
    ST_HOLDING,
    ST_LATCHED
  } state_t;

  logic [N_CH-1:0] s_q;
  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [DW-1:0]   dcnt_q  [N_CH];
  logic [DW-1:0]   dcnt_d  [N_CH];
  logic [HW-1:0]   hcnt_q  [N_CH];
  logic [HW-1:0]   hcnt_d  [N_CH];
  logic [TW-1:0]   tcnt_q;
  logic            tone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      tcnt_q <= '0;
      tone_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
    end else if (ena) begin
      s_q <= sensor_i;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
      if (tcnt_q == TW'(BEEP_HALF - 1)) begin
        tcnt_q <= '0;
        tone_q <= ~tone_q;
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (s_q[i]) begin
            state_d[i] = ST_ARM;
            dcnt_d[i]  = DW'(1);
          end
        end
        ST_ARM: begin
          if (!s_q[i]) begin
            state_d[i] = ST_IDLE;
          end else if (dcnt_q[i] == DW'(DEBOUNCE - 1)) begin
            state_d[i] = ST_ALARM;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
          end
        end
        ST_ALARM: begin
          if (!s_q[i]) begin
            state_d[i] = ST_HOLDING;
            hcnt_d[i]  = '0;
          end
        end
        ST_HOLDING: begin
          // A returning sensor goes straight back to ALARM without re-debounce.
          if (s_q[i]) begin
            state_d[i] = ST_ALARM;
          end else if (hcnt_q[i] == HW'(HOLD - 1)) begin
            state_d[i] = (LATCH != 0) ? ST_LATCHED : ST_IDLE;
          end else begin
            hcnt_d[i] = hcnt_q[i] + HW'(1);
          end
        end
        ST_LATCHED: begin
          if (ack_i[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alarm_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      alarm_o[i] = (state_q[i] == ST_ALARM) || (state_q[i] == ST_HOLDING) ||
                   (state_q[i] == ST_LATCHED);
    end
  end

  always_comb begin
    active_count_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      active_count_o = active_count_o + CNT_W'(alarm_o[i]);
    end
  end

  // Tone phase is shared, so all alarmed buzzers toggle together.
  assign buzzer_o = alarm_o & {N_CH{tone_q & ena}};

endmodule

// File: tb/tb_sensor_alarm_array.sv
module tb_sensor_alarm_array;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int BH = 5;
  localparam int H  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [N-1:0] sensor;
  logic [N-1:0] ack;
  logic [N-1:0] buz0, alm0, buz1, alm1;
  logic [3:0]   cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sensor_alarm_array #(.N_CH(N), .DEBOUNCE(D), .BEEP_HALF(BH), .HOLD(H), .LATCH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_i(sensor), .ack_i(ack),
    .buzzer_o(buz0), .alarm_o(alm0), .active_count_o(cnt0)
  );

  sensor_alarm_array #(.N_CH(N), .DEBOUNCE(D), .BEEP_HALF(BH), .HOLD(H), .LATCH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_i(sensor), .ack_i(ack),
    .buzzer_o(buz1), .alarm_o(alm1), .active_count_o(cnt1)
  );

  // Reference model: alarm level per channel expressed as run lengths of
  // high and low samples; tone is derived from the count of enabled edges.
  logic [N-1:0] m_sq;
  int           m_streak  [2][N];
  int           m_lows    [2][N];
  bit           m_alarm   [2][N];
  bit           m_latched [2][N];
  int           ecount;

  task automatic model_reset();
    m_sq   = '0;
    ecount = 0;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < N; i++) begin
        m_streak[l][i]  = 0;
        m_lows[l][i]    = 0;
        m_alarm[l][i]   = 1'b0;
        m_latched[l][i] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < N; i++) begin
        if (m_latched[l][i]) begin
          if (ack[i]) begin
            m_latched[l][i] = 1'b0;
            m_alarm[l][i]   = 1'b0;
            m_streak[l][i]  = 0;
          end
        end else if (m_alarm[l][i]) begin
          if (m_sq[i]) m_lows[l][i] = 0;
          else         m_lows[l][i]++;
          if (m_lows[l][i] == H + 1) begin
            if (l == 1) m_latched[l][i] = 1'b1;
            else begin
              m_alarm[l][i]  = 1'b0;
              m_streak[l][i] = 0;
            end
          end
        end else begin
          if (m_sq[i]) begin
            m_streak[l][i]++;
            if (m_streak[l][i] == D) begin
              m_alarm[l][i] = 1'b1;
              m_lows[l][i]  = 0;
            end
          end else begin
            m_streak[l][i] = 0;
          end
        end
      end
    m_sq = sensor;
    ecount++;
  endtask

  function automatic logic [N-1:0] exp_alarm(input int l);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = m_alarm[l][i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e0, e1, b0, b1;
    logic         tone;
    e0   = exp_alarm(0);
    e1   = exp_alarm(1);
    tone = ((ecount / BH) % 2) == 1;
    b0   = (tone && ena) ? e0 : '0;
    b1   = (tone && ena) ? e1 : '0;
    chk("alarm0", 32'(alm0), 32'(e0));
    chk("buzz0",  32'(buz0), 32'(b0));
    chk("count0", 32'(cnt0), 32'($countones(e0)));
    chk("alarm1", 32'(alm1), 32'(e1));
    chk("buzz1",  32'(buz1), 32'(b1));
    chk("count1", 32'(cnt1), 32'($countones(e1)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alarm0"}, 32'(alm0), 32'h0);
    chk({tag, "_buzz0"},  32'(buz0), 32'h0);
    chk({tag, "_count0"}, 32'(cnt0), 32'h0);
    chk({tag, "_alarm1"}, 32'(alm1), 32'h0);
    chk({tag, "_buzz1"},  32'(buz1), 32'h0);
    chk({tag, "_count1"}, 32'(cnt1), 32'h0);
  endtask

  task automatic cyc(input logic [N-1:0] s, input logic [N-1:0] a, input logic e);
    sensor = s;
    ack    = a;
    ena    = e;
    @(posedge clk);
    if (rst_n && e) model_step();
    #1;
    check_all();
  endtask

  // Entered at posedge+1; asserts reset between edges, checks the immediate
  // clear, then releases away from the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("in_rst");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] a;
    logic         e;
    int           n;
    logic [N-1:0] ea0;
    logic [N-1:0] ea1;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [N-1:0] rs, ra;
    logic         re;

    tbl[0]  = '{8'h01, 8'h00, 1'b1,  3, 8'h00, 8'h00};
    tbl[1]  = '{8'h01, 8'h00, 1'b1,  2, 8'h01, 8'h01};
    tbl[2]  = '{8'h01, 8'h00, 1'b1,  5, 8'h01, 8'h01};
    tbl[3]  = '{8'h00, 8'h00, 1'b1,  9, 8'h01, 8'h01};
    tbl[4]  = '{8'h00, 8'h00, 1'b1,  1, 8'h00, 8'h01};
    tbl[5]  = '{8'h02, 8'h00, 1'b1,  3, 8'h00, 8'h01};
    tbl[6]  = '{8'h00, 8'h00, 1'b1,  4, 8'h00, 8'h01};
    tbl[7]  = '{8'h00, 8'h01, 1'b1,  1, 8'h00, 8'h00};
    tbl[8]  = '{8'h06, 8'h00, 1'b1, 40, 8'h06, 8'h06};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 10, 8'h00, 8'h06};
    tbl[10] = '{8'h00, 8'h06, 1'b1,  1, 8'h00, 8'h00};
    tbl[11] = '{8'hFF, 8'h00, 1'b1, 20, 8'hFF, 8'hFF};
    tbl[12] = '{8'h00, 8'h00, 1'b1,  4, 8'hFF, 8'hFF};
    tbl[13] = '{8'hFF, 8'h00, 1'b1,  4, 8'hFF, 8'hFF};
    tbl[14] = '{8'hFF, 8'hFF, 1'b1,  3, 8'hFF, 8'hFF};
    tbl[15] = '{8'h00, 8'h00, 1'b1,  3, 8'hFF, 8'hFF};
    tbl[16] = '{8'h00, 8'h00, 1'b0,  7, 8'hFF, 8'hFF};
    tbl[17] = '{8'h00, 8'h00, 1'b1,  6, 8'hFF, 8'hFF};
    tbl[18] = '{8'h00, 8'h00, 1'b1,  1, 8'h00, 8'hFF};
    tbl[19] = '{8'h00, 8'hFF, 1'b1,  1, 8'h00, 8'h00};

    rst_n  = 1'b0;
    sensor = '0;
    ack    = '0;
    ena    = 1'b1;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed segments; every cycle is also checked against the model.
    for (int v = 0; v < 20; v++) begin
      for (int c = 0; c < tbl[v].n; c++) cyc(tbl[v].s, tbl[v].a, tbl[v].e);
      chk($sformatf("tbl%0d_alarm0", v), 32'(alm0), 32'(tbl[v].ea0));
      chk($sformatf("tbl%0d_alarm1", v), 32'(alm1), 32'(tbl[v].ea1));
      chk($sformatf("tbl%0d_count0", v), 32'(cnt0), 32'($countones(tbl[v].ea0)));
    end

    // Reset in the middle of an alarm: no residual hold or latch, and a
    // still-high sensor must debounce again from scratch.
    for (int c = 0; c < 6; c++) cyc(8'hFF, 8'h00, 1'b1);
    chk("pre_rst_alarm0", 32'(alm0), 32'hFF);
    do_reset();
    for (int c = 0; c < 4; c++) cyc(8'hFF, 8'h00, 1'b1);
    chk("post_rst_debounce", 32'(alm0), 32'h00);
    cyc(8'hFF, 8'h00, 1'b1);
    chk("post_rst_alarm", 32'(alm0), 32'hFF);

    // Ack while the sensor is still high re-arms through debounce.
    for (int c = 0; c < 12; c++) cyc(8'h00, 8'h00, 1'b1);
    chk("latched_hold", 32'(alm1), 32'hFF);
    cyc(8'h10, 8'hFF, 1'b1);
    chk("ack_clear", 32'(alm1), 32'h00);
    for (int c = 0; c < 3; c++) cyc(8'h10, 8'h00, 1'b1);
    chk("rearm_wait", 32'(alm1), 32'h00);
    cyc(8'h10, 8'h00, 1'b1);
    chk("rearm_alarm", 32'(alm1), 32'h10);

    // Randomised traffic against the model.
    rs = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) rs[i] = ~rs[i];
      ra = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      re = ($urandom_range(0, 9) != 0);
      cyc(rs, ra, re);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
